// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: valid/ready CPU requests in, registered addr/strobes plus tristate data out to an async-strobe memory, rsp pulse back
module mem_bus_ctrl #(
  parameter int ADDR_W        = 6,
  parameter int DATA_W        = 8,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic              mem_read,
  inout  wire  [DATA_W-1:0] mem_data
);
  localparam int MAXC = SETUP_CYCLES > STROBE_CYCLES ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int CW = $clog2(MAXC);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t r_state, w_nstate;
  logic [CW-1:0] r_cnt, w_ncnt;
  logic [DATA_W-1:0] r_wdata;
  logic r_we, r_drv, w_acc, w_last, w_we;
  logic w_ready, w_rsp, w_wr, w_rd, w_drv;
  assign mem_data = r_drv ? r_wdata : 'z;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_drv     <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_cnt     <= w_ncnt;
      r_we      <= w_we;
      r_wdata   <= w_acc ? req_wdata : r_wdata;
      r_drv     <= w_drv;
      req_ready <= w_ready;
      rsp_valid <= w_rsp;
      rsp_rdata <= (r_state == STROBE && w_last && !r_we) ? mem_data : rsp_rdata;
      mem_addr  <= w_acc ? req_addr : mem_addr;
      mem_write <= w_wr;
      mem_read  <= w_rd;
    end
  end
  always_comb begin
    w_acc    = r_state == IDLE && req_valid;
    w_last   = r_cnt == '0;
    w_nstate = r_state == IDLE   ? (req_valid ? SETUP : IDLE) :
               r_state == SETUP  ? (w_last ? STROBE : SETUP) :
               r_state == STROBE ? (w_last ? HOLD : STROBE) : IDLE;
    w_ncnt   = w_acc ? CW'(SETUP_CYCLES - 1) :
               (r_state == SETUP && w_last) ? CW'(STROBE_CYCLES - 1) :
               w_last ? '0 : r_cnt - CW'(1);
  end
  always_comb begin
    w_we    = w_acc ? req_we : r_we;
    w_ready = w_nstate == IDLE;
    w_rsp   = w_nstate == HOLD;
    w_wr    = w_nstate == STROBE && w_we;
    w_rd    = w_nstate == STROBE && !w_we;
    w_drv   = w_nstate != IDLE && w_we;
  end
endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Clocked sequencer between the CPU core and the asynchronous-strobe 64x8 memory.
- Accepts one read or write request at a time on a valid/ready handshake.
- Generates address setup, a WRITE or READ strobe pulse and a hold interval, and owns the 8-bit tristate data bus on the memory side.
- Returns read data with a one-cycle response pulse. Write completion also pulses the response.

Parameters:
- ADDR_W, 6, memory address width.
- DATA_W, 8, data bus width.
- SETUP_CYCLES, 1, cycles the address (and write data) are stable before the strobe rises; legal range >= 1.
- STROBE_CYCLES, 2, cycles the strobe is held high; legal range >= 2.

Ports:
- clk  in  1  Single clock; all state changes on its rising edge.
- reset  in  1  Synchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  Controller idle; request accepted when req_valid && req_ready at a clk edge.
- req_we  in  1  1 = write, 0 = read; sampled at acceptance.
- req_addr  in  ADDR_W  Request address; sampled at acceptance.
- req_wdata  in  DATA_W  Write data; sampled at acceptance.
- rsp_valid  out  1  One-cycle pulse marking transaction completion.
- rsp_rdata  out  DATA_W  Last read data; valid when rsp_valid is high after a read.
- mem_addr  out  ADDR_W  Address to memory.
- mem_write  out  1  WRITE strobe to memory.
- mem_read  out  1  READ strobe to memory.
- mem_data  inout  DATA_W  Shared memory data bus.

Behaviour:
- All outputs are registered, except mem_data, which is a tristate driven from the registered write data and a registered drive enable.
- States: IDLE, SETUP, STROBE, HOLD. A single counter, wide enough for max(SETUP_CYCLES, STROBE_CYCLES), times SETUP and STROBE.
- Reset (synchronous):
  - state IDLE; req_ready 1; rsp_valid 0; rsp_rdata 0.
  - mem_addr 0; mem_write 0; mem_read 0; drive enable 0, so mem_data is Z.
  - The latched request and counter are cleared.
- IDLE:
  - req_ready = 1; strobes 0; bus Z.
  - On req_valid: latch we, addr, wdata; load counter; go to SETUP; req_ready drops in the next cycle.
- SETUP:
  - mem_addr = latched addr. On a write, the bus is driven with latched wdata; on a read it stays Z.
  - Strobes 0.
  - Lasts exactly SETUP_CYCLES cycles, then STROBE.
- STROBE:
  - mem_write = we, or mem_read = !we, held high for exactly STROBE_CYCLES cycles. The other strobe is 0.
  - Address and write data are held.
  - For a read, mem_data is sampled into rsp_rdata at the clk edge that ends the final STROBE cycle.
- HOLD (1 cycle):
  - Strobes 0; address and write-data drive held for hold time.
  - rsp_valid = 1 for this cycle only. Then IDLE, where the bus is released to Z.
- Timing:
  - Latency: rsp_valid is high in cycle SETUP_CYCLES+STROBE_CYCLES+1 after the accepting edge (4 with defaults).
  - req_ready returns one cycle later.
  - Maximum throughput: one transaction per SETUP_CYCLES+STROBE_CYCLES+2 cycles (5).
- Exactly one strobe rising edge per transaction. mem_write and mem_read are never high simultaneously.
- The controller never drives mem_data while mem_read is high. The bus is Z in IDLE and during reads.
- req_valid while req_ready = 0 is ignored. The CPU keeps the request asserted until accepted; no queuing.
- Changes on req_* after acceptance have no effect on the in-flight transaction.
- rsp_rdata holds its value across writes and idle cycles; only a completed read updates it.
- Reset mid-transaction:
  - Next cycle: strobes 0, bus Z, state IDLE, no rsp_valid.
  - A write cut during STROBE may already have committed, since the memory latches on the strobe's rising edge. Memory contents at that address are then unspecified to the CPU.
- Address width matches memory exactly; no range check or wrap is needed.

Test Plan:
- Write 0xA5 to addr 0x05, then read addr 0x05:
  - mem_write high exactly 2 cycles, with mem_addr = 0x05 and mem_data = 0xA5 stable from SETUP through HOLD.
  - Read rsp_valid occurs 4 cycles after acceptance with rsp_rdata = 0xA5.
- Preloaded memory, read addr 0x00 and addr 0x3F:
  - rsp_rdata matches the preload file values; mem_write stays 0; the controller's bus drive stays Z throughout.
- req_valid held high for 12 cycles with alternating write 0x11 to 0x10 and read of 0x10:
  - Accepts occur every 5 cycles; exactly one strobe pulse per transaction; read returns 0x11.
- New req_addr/req_wdata applied while req_ready = 0 mid-transaction:
  - Ignored; the in-flight mem_addr and data are unchanged; the new request is accepted only at the next IDLE.
- Reset asserted during the second STROBE cycle of a read:
  - Next cycle mem_read 0, state IDLE, req_ready 1, no rsp_valid, rsp_rdata 0.
  - A subsequent read of a known location completes normally.
- Bus/strobe checker for the whole run:
  - mem_write and mem_read never both 1.
  - The controller never drives mem_data while mem_read = 1.
  - mem_addr never changes while either strobe is high.
